// File: rtl/awg_pulse_sequencer.sv
`timescale 1ns/1ps
// awg_pulse_sequencer: steps through a small table of pulse entries and drives
// amplitude/durations plus a one-cycle trigger into the waveform generator,
// waiting one full pulse period between triggers.
// Optional feature macro: AWG_SEQ_TRIG_CNT_EN adds the saturating o_trig_cnt output.
module awg_pulse_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned AMP_W = 16,
    parameter int unsigned DUR_W = 32,
    parameter int unsigned REP_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [AMP_W-1:0] cfg_amp,
    input  logic [DUR_W-1:0] cfg_data_dur,
    input  logic [DUR_W-1:0] cfg_zero_dur,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic [AW:0]      i_seq_len,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_loop,
    input  logic             DAC_READY,
    output logic             o_trigger,
    output logic [AMP_W-1:0] o_valid_amp,
    output logic [DUR_W-1:0] o_data_duration,
    output logic [DUR_W-1:0] o_zero_duration,
    output logic             o_stop,
    output logic             o_busy,
    output logic [AW-1:0]    o_entry_idx,
    output logic             o_done,
    output logic             o_link_lost
`ifdef AWG_SEQ_TRIG_CNT_EN
    ,
    output logic [31:0]      o_trig_cnt
`endif
);

    localparam int unsigned LEN_W = AW + 1;
    localparam int unsigned SUM_W = DUR_W + 1;

    typedef struct packed {
        logic [AMP_W-1:0] amp;
        logic [DUR_W-1:0] data_dur;
        logic [DUR_W-1:0] zero_dur;
        logic [REP_W-1:0] rep;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_TRIG = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    entry_t           mem [DEPTH];
    entry_t           rd_entry;
    state_t           state_q;
    state_t           state_d;
    logic             done_d;
    logic [AW-1:0]    idx_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_q;
    logic [SUM_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             loop_q;

    logic             stop_ev;
    logic             start_ok;
    logic [LEN_W-1:0] len_clamp;
    logic [SUM_W-1:0] dur_sum;
    logic [SUM_W-1:0] period;
    logic             rep_more;
    logic             entry_more;
    logic             last_pulse;
    logic             expire;

    assign o_entry_idx = idx_q;
    assign rd_entry    = mem[idx_q];

    // Run control decodes: abort, accepted start, period and end-of-run lookups
    assign stop_ev    = (state_q != S_IDLE) && (i_stop || !DAC_READY);
    assign start_ok   = (state_q == S_IDLE) && i_start && !i_stop && DAC_READY
                        && (i_seq_len != '0);
    assign len_clamp  = (i_seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_seq_len;
    assign dur_sum    = SUM_W'(o_data_duration) + SUM_W'(o_zero_duration);
    assign period     = (dur_sum == '0) ? SUM_W'(1) : dur_sum;
    assign rep_more   = rep_cnt_q < rep_q;
    assign entry_more = (LEN_W'(idx_q) + LEN_W'(1)) < len_q;
    assign last_pulse = !rep_more && !entry_more && !loop_q;
    assign expire     = (state_q == S_WAIT) && (cnt_q == SUM_W'(1));

    // Table storage; not reset, writable only while idle
    always_ff @(posedge sys_clk) begin
        if (cfg_we && !o_busy) begin
            mem[cfg_addr] <= '{amp: cfg_amp, data_dur: cfg_data_dur,
                               zero_dur: cfg_zero_dur, rep: cfg_rep};
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; o_done is looked ahead so it lands on the final WAIT cycle
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_TRIG;
            end
            S_TRIG: begin
                state_d = S_WAIT;
                done_d  = last_pulse && (period == SUM_W'(1));
            end
            S_WAIT: begin
                if (expire) begin
                    if (rep_more) begin
                        state_d = S_TRIG;
                    end else if (entry_more || loop_q) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    done_d = last_pulse && (cnt_q == SUM_W'(2));
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (stop_ev) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // Datapath: indices, period counter and registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q           <= '0;
            rep_cnt_q       <= '0;
            rep_q           <= '0;
            cnt_q           <= '0;
            len_q           <= '0;
            loop_q          <= 1'b0;
            o_trigger       <= 1'b0;
            o_valid_amp     <= '0;
            o_data_duration <= '0;
            o_zero_duration <= '0;
            o_stop          <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_link_lost     <= 1'b0;
        end else begin
            o_trigger <= (state_d == S_TRIG);
            o_busy    <= (state_d != S_IDLE);
            o_done    <= done_d;
            o_stop    <= i_stop || stop_ev;

            if (start_ok) begin
                idx_q       <= '0;
                rep_cnt_q   <= '0;
                len_q       <= len_clamp;
                loop_q      <= i_loop;
                o_link_lost <= 1'b0;
            end

            if ((state_q != S_IDLE) && !DAC_READY) begin
                o_link_lost <= 1'b1;
            end

            if (!stop_ev) begin
                case (state_q)
                    S_LOAD: begin
                        o_valid_amp     <= rd_entry.amp;
                        o_data_duration <= rd_entry.data_dur;
                        o_zero_duration <= rd_entry.zero_dur;
                        rep_q           <= rd_entry.rep;
                    end
                    S_TRIG: begin
                        cnt_q <= period;
                    end
                    S_WAIT: begin
                        if (expire) begin
                            if (rep_more) begin
                                rep_cnt_q <= rep_cnt_q + REP_W'(1);
                            end else if (entry_more) begin
                                rep_cnt_q <= '0;
                                idx_q     <= idx_q + AW'(1);
                            end else if (loop_q) begin
                                rep_cnt_q <= '0;
                                idx_q     <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - SUM_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef AWG_SEQ_TRIG_CNT_EN
    // Saturating trigger count for the current run, held while idle
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_trig_cnt <= '0;
        end else if (start_ok) begin
            o_trig_cnt <= '0;
        end else if ((state_d == S_TRIG) && (o_trig_cnt != 32'hFFFF_FFFF)) begin
            o_trig_cnt <= o_trig_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_awg_pulse_sequencer.sv
`timescale 1ns/1ps
// Bench for awg_pulse_sequencer: single-entry vector table, directed corner
// sequences and randomized tables checked against an event-list model.
module tb_awg_pulse_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_amp = '0;
    logic [31:0] cfg_data_dur = '0;
    logic [31:0] cfg_zero_dur = '0;
    logic [7:0]  cfg_rep = '0;
    logic [4:0]  i_seq_len = '0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_loop = 1'b0;
    logic        DAC_READY = 1'b1;
    logic        o_trigger;
    logic [15:0] o_valid_amp;
    logic [31:0] o_data_duration;
    logic [31:0] o_zero_duration;
    logic        o_stop;
    logic        o_busy;
    logic [3:0]  o_entry_idx;
    logic        o_done;
    logic        o_link_lost;
`ifdef AWG_SEQ_TRIG_CNT_EN
    logic [31:0] o_trig_cnt;
`endif

    awg_pulse_sequencer dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_amp(cfg_amp),
        .cfg_data_dur(cfg_data_dur),
        .cfg_zero_dur(cfg_zero_dur),
        .cfg_rep(cfg_rep),
        .i_seq_len(i_seq_len),
        .i_start(i_start),
        .i_stop(i_stop),
        .i_loop(i_loop),
        .DAC_READY(DAC_READY),
        .o_trigger(o_trigger),
        .o_valid_amp(o_valid_amp),
        .o_data_duration(o_data_duration),
        .o_zero_duration(o_zero_duration),
        .o_stop(o_stop),
        .o_busy(o_busy),
        .o_entry_idx(o_entry_idx),
        .o_done(o_done),
        .o_link_lost(o_link_lost)
`ifdef AWG_SEQ_TRIG_CNT_EN
        ,
        .o_trig_cnt(o_trig_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [15:0] amp;
        logic [31:0] dd;
        logic [31:0] zd;
        logic [7:0]  rep;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [15:0] amp;
        logic [31:0] dd;
        logic [31:0] zd;
        int          idx;
    } ev_t;

    typedef struct {
        logic [15:0] amp;
        logic [31:0] dd;
        logic [31:0] zd;
        logic [7:0]  rep;
        int          n_trig;
        int          gap;
        int          done_off;
    } vec_t;

    ent_t tb_mem [16];
    ev_t  obs [$];
    ev_t  expq [$];
    int   done_cyc [$];
    int   stop_cyc [$];
    int   cyc = 0;
    int   busy_fall = -1;
    bit   prev_busy = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp_v);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Advance one clock and record output events, sampled 1ns after the edge
    task automatic tick();
        ev_t e;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (o_trigger) begin
            e.cyc = cyc;
            e.amp = o_valid_amp;
            e.dd  = o_data_duration;
            e.zd  = o_zero_duration;
            e.idx = int'(o_entry_idx);
            obs.push_back(e);
        end
        if (o_done) done_cyc.push_back(cyc);
        if (o_stop) stop_cyc.push_back(cyc);
        if (prev_busy && !o_busy) busy_fall = cyc;
        prev_busy = o_busy;
    endtask

    task automatic clear_obs();
        obs.delete();
        done_cyc.delete();
        stop_cyc.delete();
        busy_fall = -1;
    endtask

    task automatic cfg_write(input int addr, input ent_t e, input bit upd);
        cfg_we       = 1'b1;
        cfg_addr     = 4'(addr);
        cfg_amp      = e.amp;
        cfg_data_dur = e.dd;
        cfg_zero_dur = e.zd;
        cfg_rep      = e.rep;
        tick();
        cfg_we = 1'b0;
        if (upd) tb_mem[addr] = e;
    endtask

    // Returns the cycle in which the DUT should sit in its first LOAD
    task automatic start_run(input int len, input bit lp, output int s);
        i_seq_len = 5'(len);
        i_loop    = lp;
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        s = cyc;
    endtask

    task automatic run_to_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        check(!o_busy, {tag, " finish"}, 64'(o_busy), 64'd0);
        tick();
        tick();
    endtask

    function automatic longint period_of(input ent_t e);
        longint sum;
        sum = longint'(e.dd) + longint'(e.zd);
        return (sum == 0) ? 64'sd1 : sum;
    endfunction

    // Expected trigger list from the table: each entry fires rep+1 times,
    // P+1 cycles apart, plus one LOAD cycle when the entry changes
    task automatic build_expected(input int s, input int len, input bit lp,
                                  input int limit, output int done_at);
        int     n;
        int     t;
        int     e;
        int     last_t;
        longint p;
        ev_t    ev;
        n       = (len > 16) ? 16 : len;
        t       = s + 1;
        e       = 0;
        last_t  = t;
        p       = 1;
        done_at = -1;
        expq.delete();
        while (t <= limit) begin
            p = period_of(tb_mem[e]);
            for (int r = 0; r <= int'(tb_mem[e].rep); r++) begin
                if (t <= limit) begin
                    ev.cyc = t;
                    ev.amp = tb_mem[e].amp;
                    ev.dd  = tb_mem[e].dd;
                    ev.zd  = tb_mem[e].zd;
                    ev.idx = e;
                    expq.push_back(ev);
                end
                last_t = t;
                t = t + int'(p) + 1;
            end
            t = t + 1;
            e++;
            if (e == n) begin
                if (!lp) begin
                    done_at = last_t + int'(p);
                    break;
                end
                e = 0;
            end
        end
    endtask

    task automatic compare_events(input string tag, input int done_at);
        int  m;
        bit  ok;
        check(obs.size() == expq.size(), {tag, " trigger count"},
              64'(obs.size()), 64'(expq.size()));
        m = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < m; i++) begin
            ok = (obs[i].cyc == expq[i].cyc) && (obs[i].amp == expq[i].amp) &&
                 (obs[i].dd == expq[i].dd) && (obs[i].zd == expq[i].zd) &&
                 (obs[i].idx == expq[i].idx);
            check(ok, {tag, " trigger {cyc,amp,idx}"},
                  {32'(obs[i].cyc), obs[i].amp, 16'(obs[i].idx)},
                  {32'(expq[i].cyc), expq[i].amp, 16'(expq[i].idx)});
        end
        if (done_at >= 0) begin
            check(done_cyc.size() == 1 && done_cyc[0] == done_at, {tag, " done cycle"},
                  64'((done_cyc.size() > 0) ? done_cyc[0] : -1), 64'(done_at));
        end else begin
            check(done_cyc.size() == 0, {tag, " no done"}, 64'(done_cyc.size()), 64'd0);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int   s;
        int   s2;
        int   da;
        int   cs;
        int   nobs;
        int   len;
        ent_t e;

        vecs[0] = '{16'h4000, 32'd10, 32'd5, 8'd0, 1, 16, 15};
        vecs[1] = '{16'h4000, 32'd10, 32'd5, 8'd2, 3, 16, 15};
        vecs[2] = '{16'h1234, 32'd0,  32'd0, 8'd2, 3, 2,  1};
        vecs[3] = '{16'h00FF, 32'd0,  32'd7, 8'd1, 2, 8,  7};
        vecs[4] = '{16'hFFFF, 32'd1,  32'd0, 8'd3, 4, 2,  1};
        vecs[5] = '{16'h8001, 32'd3,  32'd4, 8'd0, 1, 8,  7};

        // Reset values
        repeat (3) @(posedge sys_clk);
        #1;
        check({o_trigger, o_stop, o_busy, o_done, o_link_lost} == 5'b0, "reset flags",
              64'({o_trigger, o_stop, o_busy, o_done, o_link_lost}), 64'd0);
        check(o_valid_amp == 16'd0 && o_entry_idx == 4'd0, "reset amp/idx",
              64'({o_valid_amp, o_entry_idx}), 64'd0);
        check(o_data_duration == 32'd0 && o_zero_duration == 32'd0, "reset durations",
              {o_data_duration, o_zero_duration}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single-entry vector table
        for (int v = 0; v < 6; v++) begin
            e.amp = vecs[v].amp;
            e.dd  = vecs[v].dd;
            e.zd  = vecs[v].zd;
            e.rep = vecs[v].rep;
            cfg_write(0, e, 1'b1);
            clear_obs();
            start_run(1, 1'b0, s);
            check(o_busy, "vec busy after start", 64'(o_busy), 64'd1);
            run_to_idle(500, "vec");
            check(obs.size() == vecs[v].n_trig, "vec trigger count",
                  64'(obs.size()), 64'(vecs[v].n_trig));
            if (obs.size() > 0) begin
                check(obs[0].cyc == s + 1 && obs[0].amp == vecs[v].amp, "vec first trigger",
                      {32'(obs[0].cyc), 32'(obs[0].amp)}, {32'(s + 1), 32'(vecs[v].amp)});
                for (int i = 1; i < obs.size(); i++) begin
                    check(obs[i].cyc - obs[i-1].cyc == vecs[v].gap, "vec spacing",
                          64'(obs[i].cyc - obs[i-1].cyc), 64'(vecs[v].gap));
                end
                check(done_cyc.size() == 1 &&
                      done_cyc[0] - obs[obs.size()-1].cyc == vecs[v].done_off,
                      "vec done offset",
                      64'((done_cyc.size() > 0) ? done_cyc[0] - obs[obs.size()-1].cyc : -1),
                      64'(vecs[v].done_off));
                check(done_cyc.size() > 0 && busy_fall == done_cyc[0] + 1, "vec busy fall",
                      64'(busy_fall), 64'((done_cyc.size() > 0) ? done_cyc[0] + 1 : -1));
            end
`ifdef AWG_SEQ_TRIG_CNT_EN
            check(o_trig_cnt == 32'(vecs[v].n_trig), "vec trig_cnt",
                  64'(o_trig_cnt), 64'(vecs[v].n_trig));
`endif
        end

        // Three entries with D+Z=4 in loop mode, then abort
        e = '{16'h1111, 32'd2, 32'd2, 8'd0}; cfg_write(0, e, 1'b1);
        e = '{16'h2222, 32'd4, 32'd0, 8'd1}; cfg_write(1, e, 1'b1);
        e = '{16'h3333, 32'd1, 32'd3, 8'd0}; cfg_write(2, e, 1'b1);
        clear_obs();
        start_run(3, 1'b1, s);
        i_loop = 1'b0;
        i_seq_len = 5'd1;
        while (cyc < s + 60) tick();
        cs = cyc;
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check(o_stop && !o_busy && !o_trigger, "loop stop response",
              64'({o_stop, o_busy, o_trigger}), 64'b100);
        repeat (50) tick();
        build_expected(s, 3, 1'b1, cs, da);
        compare_events("loop", da);
        check(stop_cyc.size() == 1 && stop_cyc[0] == cs + 1, "loop stop cycle",
              64'((stop_cyc.size() > 0) ? stop_cyc[0] : -1), 64'(cs + 1));

        // Abort three cycles into WAIT
        e = '{16'h4000, 32'd10, 32'd5, 8'd0}; cfg_write(0, e, 1'b1);
        clear_obs();
        start_run(1, 1'b0, s);
        while (cyc < s + 4) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check(o_stop && !o_busy, "wait stop response", 64'({o_stop, o_busy}), 64'b10);
        nobs = obs.size();
        repeat (50) tick();
        check(obs.size() == nobs && nobs == 1, "no trigger after stop",
              64'(obs.size()), 64'd1);
        check(done_cyc.size() == 0, "no done after stop", 64'(done_cyc.size()), 64'd0);

        // Start and stop together: stop wins
        i_seq_len = 5'd1;
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b0;
        check(o_stop && !o_busy, "start+stop", 64'({o_stop, o_busy}), 64'b10);
        tick();

        // Zero-length sequence is not started
        i_seq_len = 5'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        check(!o_busy, "len0 ignored", 64'(o_busy), 64'd0);

        // Link loss mid-run, start blocked while link down
        clear_obs();
        start_run(1, 1'b0, s);
        while (cyc < s + 6) tick();
        DAC_READY = 1'b0;
        tick();
        check(o_link_lost && !o_busy && o_stop, "link lost response",
              64'({o_link_lost, o_busy, o_stop}), 64'b101);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        check(!o_busy && o_link_lost, "start blocked w/o link",
              64'({o_busy, o_link_lost}), 64'b01);
        DAC_READY = 1'b1;
        tick();
        start_run(1, 1'b0, s2);
        check(o_busy && !o_link_lost, "restart clears link_lost",
              64'({o_busy, o_link_lost}), 64'b10);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();

        // Zero-duration entry; write while busy must be dropped
        e = '{16'h1234, 32'd0, 32'd0, 8'd2}; cfg_write(0, e, 1'b1);
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            start_run(1, 1'b0, s);
            e = '{16'hBEEF, 32'd9, 32'd9, 8'd0};
            cfg_write(0, e, 1'b0);
            run_to_idle(100, "busy write");
            build_expected(s, 1, 1'b0, 1 << 30, da);
            compare_events("busy write", da);
`ifdef AWG_SEQ_TRIG_CNT_EN
            check(o_trig_cnt == 32'd3, "busy write trig_cnt", 64'(o_trig_cnt), 64'd3);
`endif
        end

        // Length above DEPTH is clamped
        for (int a = 0; a < 16; a++) begin
            e.amp = 16'(16'h0100 + a);
            e.dd  = 32'(a % 3);
            e.zd  = 32'd1;
            e.rep = 8'd0;
            cfg_write(a, e, 1'b1);
        end
        clear_obs();
        start_run(20, 1'b0, s);
        run_to_idle(400, "clamp");
        build_expected(s, 20, 1'b0, 1 << 30, da);
        compare_events("clamp", da);

        // Randomized tables; len/loop changed after start must not matter
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < 16; a++) begin
                e.amp = 16'($urandom);
                e.dd  = 32'($urandom_range(0, 6));
                e.zd  = 32'($urandom_range(0, 6));
                e.rep = 8'($urandom_range(0, 2));
                cfg_write(a, e, 1'b1);
            end
            len = int'($urandom_range(1, 20));
            clear_obs();
            start_run(len, 1'b0, s);
            i_seq_len = 5'($urandom_range(0, 31));
            i_loop = 1'b1;
            run_to_idle(2000, "random");
            i_loop = 1'b0;
            build_expected(s, len, 1'b0, 1 << 30, da);
            compare_events("random", da);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
